pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the RISC-V core.
- Replaces the point-to-point stall wiring between stages with one block.
- Owns per-stage valid bits and per-stage load enables, RAW-hazard detection at decode (scoreboard or load-use mode), and flush on a writeback redirect (trap/branch).
- Adds a memory-stall watchdog.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_hazard_scoreboard.sv | 77 +++++++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stage indices and register-ID type.
package pipe_pkg;

  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned DE_IDX   = 0;
  localparam int unsigned EXE_IDX  = 1;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  function automatic int unsigned mem_idx(input int unsigned n);
    return n - 2;
  endfunction

  function automatic int unsigned wb_idx(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard.sv
// Per-register pending-write counters and the decode-side RAW lookup.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned REG_ID_W   = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                issue,
  input  logic [REG_ID_W-1:0] issue_rd,
  input  logic                retire,
  input  logic [REG_ID_W-1:0] retire_rd,
  input  logic [REG_ID_W-1:0] rs1,
  input  logic                rs1_use,
  input  logic [REG_ID_W-1:0] rs2,
  input  logic                rs2_use,
  output logic                hazard_c
);

  localparam int unsigned CNT_W = $clog2(NUM_STAGES) + 1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v;
  logic [NUM_REGS-1:0] dec_v;
  logic [CNT_W-1:0]    cnt1;
  logic [CNT_W-1:0]    cnt2;
  logic                busy1;
  logic                busy2;
  logic                ovf_c;
  logic                unf_c;

  // x0 is never tracked, so its strobes stay low
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (issue && issue_rd != '0) inc_v[issue_rd] = 1'b1;
    if (retire && retire_rd != '0) dec_v[retire_rd] = 1'b1;
  end

  // A write retiring this cycle is visible to the reader (write-before-read regfile)
  always_comb begin
    cnt1  = cnt_q[rs1];
    cnt2  = cnt_q[rs2];
    busy1 = rs1_use && (rs1 != '0) && (cnt1 != '0) &&
            !(dec_v[rs1] && cnt1 == CNT_W'(1));
    busy2 = rs2_use && (rs2 != '0) && (cnt2 != '0) &&
            !(dec_v[rs2] && cnt2 == CNT_W'(1));
    hazard_c = busy1 || busy2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else if (clear) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_v[r] && !dec_v[r]) cnt_q[r] <= cnt_q[r] + CNT_W'(1);
        else if (dec_v[r] && !inc_v[r]) cnt_q[r] <= cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    ovf_c = 1'b0;
    unf_c = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (inc_v[r] && !dec_v[r] && cnt_q[r] == '1) ovf_c = 1'b1;
      if (dec_v[r] && !inc_v[r] && cnt_q[r] == '0) unf_c = 1'b1;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(ovf_c && !clear));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(unf_c && !clear));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stage valids, latch enables, decode RAW stall, redirect flush, MEM watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned REG_ID_W   = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned FWD_EN     = 0,
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned WDOG_W     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_v,
  input  logic [REG_ID_W-1:0]   de_rs1,
  input  logic [REG_ID_W-1:0]   de_rs2,
  input  logic                  de_rs1_use,
  input  logic                  de_rs2_use,
  input  logic                  de_we,
  input  logic [REG_ID_W-1:0]   de_rd,
  input  logic                  exe_load,
  input  logic [REG_ID_W-1:0]   exe_drid,
  input  logic                  mem_stall,
  input  logic                  wb_v,
  input  logic                  wb_we,
  input  logic [REG_ID_W-1:0]   wb_drid,
  input  logic                  wb_redirect,
  output logic [NUM_STAGES-1:0] stage_v,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  de_stall,
  output logic                  wdog
);

  import pipe_pkg::*;

  localparam int unsigned MEM = mem_idx(NUM_STAGES);

  logic [NUM_STAGES-1:0] stage_v_d;
  logic [WDOG_W-1:0]     wdog_cnt_q;
  logic                  sb_hazard_c;
  logic                  lu_hazard_c;
  logic                  hazard_c;
  logic                  issue_c;
  logic                  retire_c;

  assign issue_c  = stage_v[DE_IDX] && stage_en[DE_IDX] && !de_stall && de_we;
  assign retire_c = wb_v && wb_we;

  generate
    if (FWD_EN == 0) begin : g_sb
      hazard_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ID_W   (REG_ID_W),
        .NUM_REGS   (NUM_REGS)
      ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (wb_redirect),
        .issue     (issue_c),
        .issue_rd  (de_rd),
        .retire    (retire_c),
        .retire_rd (wb_drid),
        .rs1       (de_rs1),
        .rs1_use   (de_rs1_use),
        .rs2       (de_rs2),
        .rs2_use   (de_rs2_use),
        .hazard_c  (sb_hazard_c)
      );
    end else begin : g_no_sb
      assign sb_hazard_c = 1'b0;
    end
  endgenerate

  // With forwarding, only a load still in EXE cannot feed the dependent in time
  assign lu_hazard_c = stage_v[EXE_IDX] && exe_load && (exe_drid != '0) &&
                       ((de_rs1_use && de_rs1 == exe_drid) ||
                        (de_rs2_use && de_rs2 == exe_drid));

  assign hazard_c = stage_v[DE_IDX] && ((FWD_EN != 0) ? lu_hazard_c : sb_hazard_c);

  // Priority: redirect > memory stall > decode hazard > advance
  always_comb begin
    stage_en  = '1;
    de_stall  = 1'b0;
    stage_v_d = {stage_v[NUM_STAGES-2:0], in_v};
    if (wb_redirect) begin
      stage_v_d = '0;
    end else if (mem_stall) begin
      stage_en[MEM:0] = '0;
      de_stall        = 1'b1;
      stage_v_d       = {1'b0, stage_v[MEM:0]};
    end else if (hazard_c) begin
      stage_en[DE_IDX]   = 1'b0;
      de_stall           = 1'b1;
      stage_v_d[DE_IDX]  = stage_v[DE_IDX];
      stage_v_d[EXE_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_v <= '0;
    else        stage_v <= stage_v_d;
  end

  // Watchdog saturates at the limit so it pulses once per stall episode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog       <= 1'b0;
    end else if (wb_redirect || !mem_stall) begin
      wdog_cnt_q <= '0;
      wdog       <= 1'b0;
    end else if (wdog_cnt_q != WDOG_W'(WDOG_LIMIT)) begin
      wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
      wdog       <= (wdog_cnt_q == WDOG_W'(WDOG_LIMIT - 1));
    end else begin
      wdog       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: scoreboard and load-use variants driven in parallel against a reference model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_v;
  logic [4:0] de_rs1, de_rs2, de_rd, exe_drid, wb_drid;
  logic       de_rs1_use, de_rs2_use, de_we, exe_load, mem_stall;
  logic       wb_v, wb_we, wb_redirect;
  logic [3:0] stage_v0, stage_en0, stage_v1, stage_en1;
  logic       de_stall0, wdog0, de_stall1, wdog1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] mv0, mv1;
  int         pend [32];
  int         wq [$];
  int         wd;
  logic       m_wdog;
  logic [3:0] snap;

  pipe_hazard_ctrl #(.NUM_STAGES(4), .REG_ID_W(5), .NUM_REGS(32), .FWD_EN(0),
                     .WDOG_LIMIT(8), .WDOG_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_use(de_rs1_use), .de_rs2_use(de_rs2_use), .de_we(de_we), .de_rd(de_rd),
    .exe_load(exe_load), .exe_drid(exe_drid), .mem_stall(mem_stall), .wb_v(wb_v),
    .wb_we(wb_we), .wb_drid(wb_drid), .wb_redirect(wb_redirect),
    .stage_v(stage_v0), .stage_en(stage_en0), .de_stall(de_stall0), .wdog(wdog0));

  pipe_hazard_ctrl #(.NUM_STAGES(4), .REG_ID_W(5), .NUM_REGS(32), .FWD_EN(1),
                     .WDOG_LIMIT(8), .WDOG_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_use(de_rs1_use), .de_rs2_use(de_rs2_use), .de_we(de_we), .de_rd(de_rd),
    .exe_load(exe_load), .exe_drid(exe_drid), .mem_stall(mem_stall), .wb_v(wb_v),
    .wb_we(wb_we), .wb_drid(wb_drid), .wb_redirect(wb_redirect),
    .stage_v(stage_v1), .stage_en(stage_en1), .de_stall(de_stall1), .wdog(wdog1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does a source register have an outstanding write the reader would miss?
  function automatic bit src_waits(input logic use_rs, input logic [4:0] rs);
    if (!use_rs || rs == 5'd0 || pend[rs] == 0) return 1'b0;
    if (wb_v && wb_we && wb_drid == rs && pend[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Expected control outputs and next valids for one variant in the current cycle
  function automatic void model_comb(input bit fwd, input logic [3:0] v,
                                     output logic [3:0] en, output logic stall,
                                     output logic [3:0] nv);
    bit haz;
    if (fwd)
      haz = v[1] && exe_load && exe_drid != 5'd0 &&
            ((de_rs1_use && de_rs1 == exe_drid) || (de_rs2_use && de_rs2 == exe_drid));
    else
      haz = src_waits(de_rs1_use, de_rs1) || src_waits(de_rs2_use, de_rs2);
    haz = haz && v[0];
    if (wb_redirect) begin
      en = 4'b1111; stall = 1'b0; nv = 4'b0000;
    end else if (mem_stall) begin
      en = 4'b1000; stall = 1'b1; nv = {1'b0, v[2:0]};
    end else if (haz) begin
      en = 4'b1110; stall = 1'b1; nv = {v[2], v[1], 1'b0, v[0]};
    end else begin
      en = 4'b1111; stall = 1'b0; nv = {v[2:0], in_v};
    end
  endfunction

  // Check all outputs at the falling edge, then advance the model across the rising edge
  task automatic step();
    logic [3:0] en0, en1, nv0, nv1;
    logic       st0, st1;
    bit         iss, ret;
    @(negedge clk);
    model_comb(1'b0, mv0, en0, st0, nv0);
    model_comb(1'b1, mv1, en1, st1, nv1);
    check("stage_v0", 32'(stage_v0), 32'(mv0));
    check("stage_en0", 32'(stage_en0), 32'(en0));
    check("de_stall0", 32'(de_stall0), 32'(st0));
    check("wdog0", 32'(wdog0), 32'(m_wdog));
    check("stage_v1", 32'(stage_v1), 32'(mv1));
    check("stage_en1", 32'(stage_en1), 32'(en1));
    check("de_stall1", 32'(de_stall1), 32'(st1));
    check("wdog1", 32'(wdog1), 32'(m_wdog));
    iss = mv0[0] && en0[0] && !st0 && de_we && de_rd != 5'd0;
    ret = wb_v && wb_we && wb_drid != 5'd0;
    if (wb_redirect) begin
      foreach (pend[r]) pend[r] = 0;
      wq.delete();
    end else begin
      if (ret) begin
        pend[wb_drid]--;
        void'(wq.pop_front());
      end
      if (iss) begin
        pend[de_rd]++;
        wq.push_back(int'(de_rd));
      end
    end
    if (wb_redirect || !mem_stall) begin
      wd = 0; m_wdog = 1'b0;
    end else if (wd < 8) begin
      wd++; m_wdog = (wd == 8);
    end else begin
      m_wdog = 1'b0;
    end
    mv0 = nv0;
    mv1 = nv1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_v = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_use = 0; de_rs2_use = 0;
    de_we = 0; de_rd = 0; exe_load = 0; exe_drid = 0; mem_stall = 0;
    wb_v = 0; wb_we = 0; wb_drid = 0; wb_redirect = 0;
  endtask

  task automatic flush();
    idle();
    wb_redirect = 1;
    step();
    idle();
  endtask

  initial begin
    mv0 = '0; mv1 = '0; wd = 0; m_wdog = 1'b0;
    foreach (pend[r]) pend[r] = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_v0", 32'(stage_v0), 32'h0);
    check("rst_en0", 32'(stage_en0), 32'hF);
    check("rst_st0", 32'(de_stall0), 32'h0);
    check("rst_wd0", 32'(wdog0), 32'h0);
    check("rst_v1", 32'(stage_v1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the pipe
    in_v = 1;
    step(); check("t1_v_a", 32'(stage_v0), 32'h1);
    step(); check("t1_v_b", 32'(stage_v0), 32'h3);
    step(); check("t1_v_c", 32'(stage_v0), 32'h7);
    step(); check("t1_v_d", 32'(stage_v0), 32'hF);

    // Scoreboard RAW on x5, released by its retirement
    flush();
    in_v = 1; step();
    de_we = 1; de_rd = 5; step();
    de_we = 0; de_rs1 = 5; de_rs1_use = 1;
    #1; check("t2_stall_a", 32'(de_stall0), 32'h1);
    check("t2_en_a", 32'(stage_en0), 32'hE);
    step(); check("t2_bub_a", 32'(stage_v0[1]), 32'h0);
    #1; check("t2_stall_b", 32'(de_stall0), 32'h1);
    step(); check("t2_bub_b", 32'(stage_v0[1]), 32'h0);
    wb_v = 1; wb_we = 1; wb_drid = 5;
    #1; check("t2_ret_go", 32'(de_stall0), 32'h0);
    step(); wb_v = 0; wb_we = 0; wb_drid = 0;
    check("t2_issued", 32'(stage_v0[1]), 32'h1);

    // Load-use with forwarding
    flush();
    in_v = 1; step(); step();
    de_rs1 = 7; de_rs1_use = 1; exe_load = 1; exe_drid = 7;
    #1; check("t3_lu_stall", 32'(de_stall1), 32'h1);
    step(); check("t3_lu_bub", 32'(stage_v1[1]), 32'h0);
    #1; check("t3_lu_once", 32'(de_stall1), 32'h0);
    step();
    exe_load = 0;
    #1; check("t3_nonload", 32'(de_stall1), 32'h0);
    step();
    exe_load = 1; exe_drid = 0; de_rs1 = 0;
    #1; check("t3_x0", 32'(de_stall1), 32'h0);
    step();

    // Memory stall masks a pending decode hazard
    flush();
    in_v = 1; step();
    de_we = 1; de_rd = 5; step();
    de_we = 0; de_rs1 = 5; de_rs1_use = 1; mem_stall = 1;
    snap = stage_v0;
    #1; check("t4_en", 32'(stage_en0), 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_frozen", 32'(stage_v0[2:0]), 32'(snap[2:0]));
      check("t4_wb_bub", 32'(stage_v0[3]), 32'h0);
    end
    mem_stall = 0; step();
    wb_v = 1; wb_we = 1; wb_drid = 5; step();
    idle();

    // Redirect beats memory stall and clears pending writes
    in_v = 1; step();
    de_we = 1; de_rd = 1; step();
    de_rd = 2; step();
    de_rd = 3; step();
    de_we = 0; wb_redirect = 1; mem_stall = 1;
    #1; check("t5_st", 32'(de_stall0), 32'h0);
    check("t5_en", 32'(stage_en0), 32'hF);
    step();
    check("t5_v0", 32'(stage_v0), 32'h0);
    check("t5_v1", 32'(stage_v1), 32'h0);
    idle(); in_v = 1; step();
    de_rs1 = 1; de_rs1_use = 1; de_rs2 = 3; de_rs2_use = 1;
    #1; check("t5_cleared", 32'(de_stall0), 32'h0);
    step();

    // Watchdog: one pulse per stall episode, restarts after a gap
    idle(); mem_stall = 1;
    for (int i = 1; i <= 20; i++) begin
      step(); check("t6_wdog", 32'(wdog0), 32'(i == 8));
    end
    mem_stall = 0; step();
    mem_stall = 1;
    for (int i = 1; i <= 8; i++) begin
      step(); check("t6_wdog_re", 32'(wdog0), 32'(i == 8));
    end
    idle(); step();

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_v        = ($urandom_range(0, 3) != 0);
      de_rs1      = 5'($urandom_range(0, 7));
      de_rs2      = 5'($urandom_range(0, 7));
      de_rs1_use  = 1'($urandom_range(0, 1));
      de_rs2_use  = 1'($urandom_range(0, 1));
      de_rd       = 5'($urandom_range(0, 7));
      de_we       = ($urandom_range(0, 1) == 1) && (pend[de_rd] < 5);
      exe_load    = 1'($urandom_range(0, 1));
      exe_drid    = 5'($urandom_range(0, 7));
      mem_stall   = ($urandom_range(0, 9) < 2);
      wb_redirect = ($urandom_range(0, 29) == 0);
      if (wq.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_v = 1; wb_we = 1; wb_drid = 5'(wq[0]);
      end else begin
        wb_v    = 1'($urandom_range(0, 1));
        wb_we   = ($urandom_range(0, 4) == 0);
        wb_drid = wb_we ? 5'd0 : 5'($urandom_range(0, 31));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
